pc_sequencer: RTL and testbench

Fetch/PC sequencing controller for the Fase-1 single-cycle datapath. It owns the 32-bit program counter and computes the sequential next PC with the team's ADD4 adder (one instance inside this block). It also selects between PC+4, branch target and jump target, and runs a request/acknowledge fetch handshake with instruction memory. Halt, resume, misalignment and bus-timeout handling are centralised here so the datapath only sees a registered instruction and a valid flag.

---
 rtl/pc_sequencer_if.sv | 10 +
 rtl/pc_sequencer.sv | 153 +++++++++++++++
 tb/tb_pc_sequencer.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/pc_sequencer_if.sv
// Instruction-memory fetch handshake between the PC sequencer and instruction memory.
interface pc_sequencer_if;
    logic        im_req;
    logic [31:0] im_addr;
    logic        im_ack;
    logic [31:0] im_rdata;

    modport master (output im_req, output im_addr, input im_ack, input im_rdata);
    modport slave  (input im_req, input im_addr, output im_ack, output im_rdata);
endinterface

// File: rtl/pc_sequencer.sv
// Fetch/PC sequencing controller: owns the PC, selects next PC, runs the IM handshake
// and centralises halt, resume, misalignment and fetch-watchdog handling.

module add4 (
    input  logic [31:0] i_a,
    output logic [31:0] o_sum
);
    assign o_sum = i_a + 32'd4;
endmodule

module pc_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned TIMEOUT  = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    pc_sequencer_if.master   im,
    output logic [31:0]      o_instr,
    output logic             o_instr_valid,
    input  logic             i_ex_done,
    input  logic             i_jump,
    input  logic [31:0]      i_jump_target,
    input  logic             i_branch_taken,
    input  logic [31:0]      i_br_target,
    input  logic             i_halt_req,
    input  logic             i_resume,
    output logic [31:0]      o_pc,
    output logic             o_halted,
    output logic             o_misalign,
    output logic             o_bus_err,
    output logic [31:0]      o_retired
);
    localparam int unsigned WD_W = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {ST_BOOT, ST_FETCH, ST_EXEC, ST_HALTED} state_t;

    state_t            r_state,       w_state_nxt;
    logic [31:0]       r_pc,          w_pc_nxt;
    logic [31:0]       r_instr,       w_instr_nxt;
    logic              r_instr_valid, w_instr_valid_nxt;
    logic              r_im_req,      w_im_req_nxt;
    logic              r_halted,      w_halted_nxt;
    logic              r_misalign,    w_misalign_nxt;
    logic              r_bus_err,     w_bus_err_nxt;
    logic [31:0]       r_retired,     w_retired_nxt;
    logic [WD_W-1:0]   r_wd_cnt,      w_wd_cnt_nxt;
    logic [WD_W-1:0]   w_wd_inc;
    logic [31:0]       w_pc_plus4;
    logic [31:0]       w_target;

    add4 u_add4 (
        .i_a   (r_pc),
        .o_sum (w_pc_plus4)
    );

    // Jump beats branch beats sequential; only the selected target is alignment-checked
    assign w_target = i_jump         ? i_jump_target :
                      i_branch_taken ? i_br_target   : w_pc_plus4;
    assign w_wd_inc = r_wd_cnt + WD_W'(1);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state       <= ST_BOOT;
            r_pc          <= RESET_PC;
            r_instr       <= 32'h0;
            r_instr_valid <= 1'b0;
            r_im_req      <= 1'b0;
            r_halted      <= 1'b0;
            r_misalign    <= 1'b0;
            r_bus_err     <= 1'b0;
            r_retired     <= 32'h0;
            r_wd_cnt      <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_pc          <= w_pc_nxt;
            r_instr       <= w_instr_nxt;
            r_instr_valid <= w_instr_valid_nxt;
            r_im_req      <= w_im_req_nxt;
            r_halted      <= w_halted_nxt;
            r_misalign    <= w_misalign_nxt;
            r_bus_err     <= w_bus_err_nxt;
            r_retired     <= w_retired_nxt;
            r_wd_cnt      <= w_wd_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt       = r_state;
        w_pc_nxt          = r_pc;
        w_instr_nxt       = r_instr;
        w_instr_valid_nxt = r_instr_valid;
        w_misalign_nxt    = r_misalign;
        w_bus_err_nxt     = r_bus_err;
        w_retired_nxt     = r_retired;
        w_wd_cnt_nxt      = r_wd_cnt;

        case (r_state)
            ST_BOOT: begin
                w_state_nxt  = ST_FETCH;
                w_wd_cnt_nxt = '0;
            end
            ST_FETCH: begin
                if (im.im_ack) begin
                    w_instr_nxt       = im.im_rdata;
                    w_instr_valid_nxt = 1'b1;
                    w_state_nxt       = ST_EXEC;
                end else if (TIMEOUT != 0) begin
                    // An ACK on the expiring edge takes the branch above, so it wins
                    if (w_wd_inc == WD_W'(TIMEOUT)) begin
                        w_bus_err_nxt = 1'b1;
                        w_state_nxt   = ST_HALTED;
                    end else begin
                        w_wd_cnt_nxt  = w_wd_inc;
                    end
                end
            end
            ST_EXEC: begin
                if (i_ex_done) begin
                    w_retired_nxt     = r_retired + 32'd1;
                    w_instr_valid_nxt = 1'b0;
                    if (w_target[1:0] != 2'b00) begin
                        w_misalign_nxt = 1'b1;
                        w_state_nxt    = ST_HALTED;
                    end else begin
                        w_pc_nxt       = w_target;
                        w_state_nxt    = i_halt_req ? ST_HALTED : ST_FETCH;
                        w_wd_cnt_nxt   = '0;
                    end
                end
            end
            ST_HALTED: begin
                if (i_resume && !r_misalign && !r_bus_err) begin
                    w_state_nxt  = ST_FETCH;
                    w_wd_cnt_nxt = '0;
                end
            end
            default: w_state_nxt = ST_BOOT;
        endcase

        w_im_req_nxt = (w_state_nxt == ST_FETCH);
        w_halted_nxt = (w_state_nxt == ST_HALTED);
    end

    assign im.im_req     = r_im_req;
    assign im.im_addr    = r_pc;
    assign o_instr       = r_instr;
    assign o_instr_valid = r_instr_valid;
    assign o_pc          = r_pc;
    assign o_halted      = r_halted;
    assign o_misalign    = r_misalign;
    assign o_bus_err     = r_bus_err;
    assign o_retired     = r_retired;
endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer with a fetched-instruction scoreboard.
module tb_pc_sequencer;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        ex_done, jump, branch_taken, halt_req, resume;
    logic [31:0] jump_target, br_target;

    logic [31:0] a_instr, a_pc, a_retired;
    logic        a_valid, a_halted, a_misalign, a_bus_err;
    logic [31:0] b_instr, b_pc, b_retired;
    logic        b_valid, b_halted, b_misalign, b_bus_err;

    int          n_pass  = 0;
    int          n_total = 0;
    int          n_fail  = 0;

    logic [31:0] exp_q[$];
    logic [31:0] exp_pc, exp_ret;
    logic        exp_mis, exp_halt;

    always #5 clk = ~clk;

    pc_sequencer_if bus_a ();
    pc_sequencer_if bus_b ();
    assign bus_b.im_ack   = bus_a.im_ack;
    assign bus_b.im_rdata = bus_a.im_rdata;

    pc_sequencer #(.RESET_PC(32'h0000_0000), .TIMEOUT(4)) dut_a (
        .i_clk(clk), .i_rst_n(rst_n), .im(bus_a),
        .o_instr(a_instr), .o_instr_valid(a_valid),
        .i_ex_done(ex_done), .i_jump(jump), .i_jump_target(jump_target),
        .i_branch_taken(branch_taken), .i_br_target(br_target),
        .i_halt_req(halt_req), .i_resume(resume),
        .o_pc(a_pc), .o_halted(a_halted), .o_misalign(a_misalign),
        .o_bus_err(a_bus_err), .o_retired(a_retired)
    );

    pc_sequencer #(.RESET_PC(32'hFFFF_FFFC), .TIMEOUT(4)) dut_b (
        .i_clk(clk), .i_rst_n(rst_n), .im(bus_b),
        .o_instr(b_instr), .o_instr_valid(b_valid),
        .i_ex_done(ex_done), .i_jump(jump), .i_jump_target(jump_target),
        .i_branch_taken(branch_taken), .i_br_target(br_target),
        .i_halt_req(halt_req), .i_resume(resume),
        .o_pc(b_pc), .o_halted(b_halted), .o_misalign(b_misalign),
        .o_bus_err(b_bus_err), .o_retired(b_retired)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Asserts reset, checks the asynchronous reset values, then releases into FETCH
    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_pc",       a_pc,          32'h0);
        chk("rst_addr",     bus_a.im_addr, 32'h0);
        chk("rst_req",      32'(bus_a.im_req), 32'h0);
        chk("rst_instr",    a_instr,       32'h0);
        chk("rst_valid",    32'(a_valid),    32'h0);
        chk("rst_halted",   32'(a_halted),   32'h0);
        chk("rst_misalign", 32'(a_misalign), 32'h0);
        chk("rst_bus_err",  32'(a_bus_err),  32'h0);
        chk("rst_retired",  a_retired,     32'h0);
        chk("rst_pc_b",     b_pc,          32'hFFFF_FFFC);
        exp_pc = 32'h0; exp_ret = 32'h0; exp_mis = 1'b0; exp_halt = 1'b0;
        exp_q.delete();
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic do_fetch(input logic [31:0] instr);
        chk("fetch_req",  32'(bus_a.im_req), 32'h1);
        chk("fetch_addr", bus_a.im_addr, exp_pc);
        bus_a.im_ack   = 1'b1;
        bus_a.im_rdata = instr;
        exp_q.push_back(instr);
        tick();
        bus_a.im_ack   = 1'b0;
        bus_a.im_rdata = 32'h0;
        chk("instr_valid", 32'(a_valid), 32'h1);
        if (a_valid) chk("instr", a_instr, exp_q.pop_front());
    endtask

    task automatic do_exec(input logic j, input logic [31:0] jt, input logic b,
                           input logic [31:0] bt, input logic h);
        logic [31:0] sel;
        ex_done = 1'b1; jump = j; jump_target = jt;
        branch_taken = b; br_target = bt; halt_req = h;
        tick();
        ex_done = 1'b0; jump = 1'b0; branch_taken = 1'b0; halt_req = 1'b0;
        exp_ret = exp_ret + 32'd1;
        sel = j ? jt : (b ? bt : exp_pc + 32'd4);
        if (sel[1:0] != 2'b00) begin
            exp_mis  = 1'b1;
            exp_halt = 1'b1;
        end else begin
            exp_pc   = sel;
            exp_halt = h;
        end
        chk("exec_pc",       a_pc, exp_pc);
        chk("exec_retired",  a_retired, exp_ret);
        chk("exec_valid",    32'(a_valid), 32'h0);
        chk("exec_halted",   32'(a_halted), 32'(exp_halt));
        chk("exec_req",      32'(bus_a.im_req), 32'(!exp_halt));
        chk("exec_misalign", 32'(a_misalign), 32'(exp_mis));
    endtask

    initial begin
        #20000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "bench time limit reached");
    end

    initial begin
        ex_done = 1'b0; jump = 1'b0; branch_taken = 1'b0; halt_req = 1'b0; resume = 1'b0;
        jump_target = 32'h0; br_target = 32'h0;
        bus_a.im_ack = 1'b0; bus_a.im_rdata = 32'h0;
        rst_n = 1'b1;
        #2;
        do_reset();

        // Sequential run 0 -> 4 -> 8 -> 12; the high-reset copy wraps to 0
        do_fetch(32'hA000_0001);
        do_exec(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        chk("wrap_pc",       b_pc, 32'h0000_0000);
        chk("wrap_misalign", 32'(b_misalign), 32'h0);
        do_fetch(32'hA000_0002);
        do_exec(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        do_fetch(32'hA000_0003);
        do_exec(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        chk("retired_3", a_retired, 32'd3);

        // Jump and branch together: jump wins
        do_fetch(32'hB000_0000);
        do_exec(1'b1, 32'h0000_0100, 1'b1, 32'h0000_0040, 1'b0);
        do_fetch(32'hB000_0100);
        do_exec(1'b1, 32'h0000_0004, 1'b0, 32'h0, 1'b0);

        // Halt at PC=4 retires to PC=8; EX_DONE while halted is ignored
        do_fetch(32'hC000_0004);
        do_exec(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        ex_done = 1'b1;
        tick();
        ex_done = 1'b0;
        chk("halt_ignore_ret", a_retired, exp_ret);
        chk("halt_ignore_pc",  a_pc, 32'h8);
        resume = 1'b1;
        tick();
        resume = 1'b0;
        chk("resume_halted", 32'(a_halted), 32'h0);
        chk("resume_req",    32'(bus_a.im_req), 32'h1);
        chk("resume_addr",   bus_a.im_addr, 32'h8);

        // ACK arriving on the 4th FETCH edge beats the watchdog
        repeat (3) tick();
        chk("wd_pre_halted",  32'(a_halted), 32'h0);
        chk("wd_pre_bus_err", 32'(a_bus_err), 32'h0);
        do_fetch(32'hD000_0008);
        chk("wd_ack_bus_err", 32'(a_bus_err), 32'h0);

        // Misaligned branch target: PC held, sticky MISALIGN, RESUME ignored
        do_exec(1'b0, 32'h0, 1'b1, 32'h0000_0042, 1'b0);
        chk("mis_pc", a_pc, 32'h8);
        resume = 1'b1;
        tick();
        resume = 1'b0;
        chk("mis_resume_halted", 32'(a_halted), 32'h1);
        chk("mis_resume_req",    32'(bus_a.im_req), 32'h0);

        // Watchdog expiry with ACK held low
        do_reset();
        repeat (3) tick();
        chk("wd3_halted",  32'(a_halted), 32'h0);
        chk("wd3_bus_err", 32'(a_bus_err), 32'h0);
        tick();
        chk("wd4_bus_err", 32'(a_bus_err), 32'h1);
        chk("wd4_halted",  32'(a_halted), 32'h1);
        chk("wd4_req",     32'(bus_a.im_req), 32'h0);
        resume = 1'b1;
        tick();
        resume = 1'b0;
        chk("wd_resume_halted", 32'(a_halted), 32'h1);

        // Asynchronous reset in the middle of EXEC
        do_reset();
        do_fetch(32'hE000_0000);
        #2;
        do_reset();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
